reg_file: RTL and testbench
===========================

# reg_file

General-purpose register file with one synchronous write port and two asynchronous read ports. It holds the datapath's working registers. The write-back stage writes to it through D. The two read ports, A and B, supply operands to the ALU. The block is purely storage: no decoding of instructions and no hazard logic beyond what is stated below.

## Interface
- `DATA_W`, default 8: width of each register and of the data ports.
- `ADDR_W`, default 8: width of each address port.
- `NUM_REGS`, default 2**ADDR_W (256): number of registers.
- `clk`  in  1: clock; all state updates on its rising edge.
- `rst_n`  in  1: reset; asynchronous, active-low.
- `data_in`  in  DATA_W: write data.
- `write`  in  1: write enable, active-high.
- `D_address`  in  ADDR_W: destination (write) register index.
- `A_address`  in  ADDR_W: read port A register index.
- `B_address`  in  ADDR_W: read port B register index.
- `A_out`  out  DATA_W: contents of register `A_address`.
- `B_out`  out  DATA_W: contents of register `B_address`.

## Operation
- Storage: NUM_REGS registers, each DATA_W bits, indexed 0..NUM_REGS-1.
- Write: on a rising `clk` edge with `write`=1 and `rst_n`=1, `reg[D_address] <= data_in`.
  - With `write`=0, no register changes, regardless of `data_in` or `D_address`.
- Read: `A_out = reg[A_address]` and `B_out = reg[B_address]`, purely combinational.
  - Both ports are independent.
  - Both ports may select the same register, and both then return the same value.
- Out-of-range index (only possible when NUM_REGS < 2**ADDR_W):
  - Reads return 0.
  - Writes are ignored.
- No write-to-read bypass: a read of `D_address` during a write cycle returns the old value until the edge.

## Timing
- Reset: `rst_n`=0 immediately clears every register to 0, independent of `clk`.
  - `A_out` and `B_out` therefore read 0 during and after reset until the first write.
- Deassertion of `rst_n` is synchronised externally. The first write can take effect on the first rising edge after release.
- Write latency: 1 cycle. The new value is visible on the read ports combinationally just after the capturing edge.
- Read latency: 0 cycles (combinational from address to output).
- Reset asserted in the same cycle as a write: reset wins and the write is lost.
- Back-to-back writes to different or identical addresses on consecutive edges are all committed in order. The last write wins.

## Configuration
- `REG_FILE_R0_ZERO_EN` defined:
  - Register 0 is hardwired to 0.
  - Writes to address 0 are discarded.
  - Reads of address 0 always return 0.
- `REG_FILE_R0_ZERO_EN` undefined: register 0 is an ordinary writable register like all others.

## Structure
- Shared package `reg_file_pkg` holds:
  - constants `REG_FILE_DATA_W` = 8, `REG_FILE_ADDR_W` = 8, `REG_FILE_NUM_REGS` = 256;
  - typedefs `reg_data_t` and `reg_addr_t`.
- One sub-module, `reg_file_rd_port`: a combinational NUM_REGS:1 read mux including the out-of-range-to-zero rule. It is instantiated twice, once for port A and once for port B.
- The storage array and the write decode live in the top level.

## Test plan
- Reset: hold `rst_n`=0, then release, with all addresses 0 -> `A_out` = `B_out` = 0x00; reading addresses 1..4 gives 0x00.
- Sequential writes: `write`=1, then on successive edges write 0xAA to 1, 0x01 to 2, 0x02 to 3. Then `A_address`=2, `B_address`=1 -> `A_out`=0x01, `B_out`=0xAA; `A_address`=3 -> 0x02.
- Write disabled: `write`=0, `data_in`=0x03, `D_address`=4, clock several edges -> reading address 4 gives 0x00.
- Read-during-write: register 5 holds 0x10; write 0x20 to 5 while `A_address`=5 -> `A_out`=0x10 before the edge, 0x20 after. Same address on both ports gives equal outputs.
- Reset mid-operation: after the writes above, pulse `rst_n` low between clock edges -> all outputs go to 0x00 immediately, with no wait for `clk`. A write coinciding with reset is not stored.
- Address 0: write 0x55 to 0 -> reads 0x00 with `REG_FILE_R0_ZERO_EN` defined, 0x55 without it.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants, types and helpers for the general-purpose register file.
package reg_file_pkg;

    localparam int unsigned REG_FILE_DATA_W   = 8;
    localparam int unsigned REG_FILE_ADDR_W   = 8;
    localparam int unsigned REG_FILE_NUM_REGS = 256;

    typedef logic [REG_FILE_DATA_W-1:0] reg_data_t;
    typedef logic [REG_FILE_ADDR_W-1:0] reg_addr_t;

    function automatic logic addr_in_range(input logic [31:0] idx, input int unsigned num);
        return idx < num;
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// Combinational NUM_REGS:1 read mux; an index with no matching register reads as zero.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W   = REG_FILE_DATA_W,
    parameter int unsigned ADDR_W   = REG_FILE_ADDR_W,
    parameter int unsigned NUM_REGS = 2**ADDR_W
) (
    input  logic [DATA_W-1:0] regs [NUM_REGS],
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data
);

    logic [31:0] idx;

    always_comb begin
        idx  = 32'(address);
        data = '0;
        // Out-of-range indices never match, so they fall through to the zero default.
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (idx == i) begin
                data = regs[i];
            end
        end
    end

endmodule

// File: rtl/reg_file.sv
// Register file: one synchronous write port (D), two combinational read ports (A, B).
// Define REG_FILE_R0_ZERO_EN to hardwire register 0 to zero.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W   = REG_FILE_DATA_W,
    parameter int unsigned ADDR_W   = REG_FILE_ADDR_W,
    parameter int unsigned NUM_REGS = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              write,
    input  logic [ADDR_W-1:0] D_address,
    input  logic [ADDR_W-1:0] A_address,
    input  logic [ADDR_W-1:0] B_address,
    output logic [DATA_W-1:0] A_out,
    output logic [DATA_W-1:0] B_out
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [31:0]       d_idx;
    logic              wr_en;

    always_comb begin
        d_idx = 32'(D_address);
        wr_en = write && addr_in_range(d_idx, NUM_REGS);
`ifdef REG_FILE_R0_ZERO_EN
        // Register 0 keeps its reset value forever, so reads of it stay zero.
        if (d_idx == 32'd0) begin
            wr_en = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (d_idx == i) begin
                    regs_q[i] <= data_in;
                end
            end
        end
    end

    reg_file_rd_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_rd_port_a (
        .regs    (regs_q),
        .address (A_address),
        .data    (A_out)
    );

    reg_file_rd_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_rd_port_b (
        .regs    (regs_q),
        .address (B_address),
        .data    (B_out)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, reset/corner sequences, random traffic.
module tb_reg_file;
    import reg_file_pkg::*;

`ifdef REG_FILE_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    logic      clk;
    logic      rst_n;
    reg_data_t data_in;
    logic      write;
    reg_addr_t D_address;
    reg_addr_t A_address;
    reg_addr_t B_address;
    reg_data_t A_out;
    reg_data_t B_out;

    int vectors;
    int miscompares;

    // Reference storage: plain array of register values.
    int model [REG_FILE_NUM_REGS];

    typedef struct {
        bit        wr;
        reg_addr_t d_addr;
        reg_data_t d_data;
        reg_addr_t a_addr;
        reg_addr_t b_addr;
        reg_data_t exp_a;
        reg_data_t exp_b;
    } vec_t;

    vec_t tbl [13];

    reg_file u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .write     (write),
        .D_address (D_address),
        .A_address (A_address),
        .B_address (B_address),
        .A_out     (A_out),
        .B_out     (B_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input reg_data_t act, input reg_data_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic reg_data_t model_read(input int addr);
        if (R0_ZERO && addr == 0) return '0;
        return reg_data_t'(model[addr]);
    endfunction

    task automatic model_write(input bit wr, input int addr, input int data);
        if (wr && !(R0_ZERO && addr == 0)) model[addr] = data;
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(REG_FILE_NUM_REGS); i++) model[i] = 0;
    endtask

    function automatic vec_t mk(input bit wr, input int d, input int dd, input int a, input int b,
                                input int ea, input int eb);
        vec_t v;
        v.wr = wr; v.d_addr = reg_addr_t'(d); v.d_data = reg_data_t'(dd);
        v.a_addr = reg_addr_t'(a); v.b_addr = reg_addr_t'(b);
        v.exp_a = reg_data_t'(ea); v.exp_b = reg_data_t'(eb);
        return v;
    endfunction

    initial begin
        int r0v;
        vectors     = 0;
        miscompares = 0;
        model_clear();
        r0v = R0_ZERO ? 0 : 'h55;

        // Each row: drive after a falling edge, check outputs before the next rising edge.
        tbl[0]  = mk(0, 0, 'h00, 1, 2, 'h00, 'h00);
        tbl[1]  = mk(0, 0, 'h00, 3, 4, 'h00, 'h00);
        tbl[2]  = mk(1, 1, 'hAA, 1, 0, 'h00, 'h00);
        tbl[3]  = mk(1, 2, 'h01, 1, 2, 'hAA, 'h00);
        tbl[4]  = mk(1, 3, 'h02, 2, 1, 'h01, 'hAA);
        tbl[5]  = mk(0, 4, 'h03, 3, 2, 'h02, 'h01);
        tbl[6]  = mk(0, 4, 'h03, 4, 4, 'h00, 'h00);
        tbl[7]  = mk(0, 4, 'h03, 4, 3, 'h00, 'h02);
        tbl[8]  = mk(1, 5, 'h10, 5, 5, 'h00, 'h00);
        tbl[9]  = mk(1, 5, 'h20, 5, 5, 'h10, 'h10);
        tbl[10] = mk(0, 0, 'h00, 5, 5, 'h20, 'h20);
        tbl[11] = mk(1, 0, 'h55, 0, 1, 'h00, 'hAA);
        tbl[12] = mk(0, 0, 'h00, 0, 0, r0v, r0v);

        rst_n = 1'b0; write = 1'b0; data_in = '0;
        D_address = '0; A_address = '0; B_address = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_a", A_out, 8'h00);
        check("reset_b", B_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            write = tbl[i].wr; D_address = tbl[i].d_addr; data_in = tbl[i].d_data;
            A_address = tbl[i].a_addr; B_address = tbl[i].b_addr;
            #1;
            check($sformatf("tbl%0d_a", i), A_out, tbl[i].exp_a);
            check($sformatf("tbl%0d_b", i), B_out, tbl[i].exp_b);
            model_write(tbl[i].wr, int'(tbl[i].d_addr), int'(tbl[i].d_data));
            @(negedge clk);
        end

        // Reset pulse between edges while a write is pending: clears at once, write lost.
        write = 1'b1; D_address = 8'd6; data_in = 8'h77; A_address = 8'd1; B_address = 8'd3;
        #1;
        check("pre_rst_a", A_out, 8'hAA);
        check("pre_rst_b", B_out, 8'h02);
        rst_n = 1'b0;
        #1;
        check("async_rst_a", A_out, 8'h00);
        check("async_rst_b", B_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1; write = 1'b0; A_address = 8'd6; B_address = 8'd5;
        #1;
        check("rst_wr_lost", A_out, 8'h00);
        check("rst_r5", B_out, 8'h00);
        model_clear();
        @(negedge clk);

        // Randomised traffic against the array model.
        for (int n = 0; n < 400; n++) begin
            write     = ($urandom_range(0, 3) != 0);
            D_address = ($urandom_range(0, 7) == 0) ? reg_addr_t'($urandom_range(0, 3))
                                                    : reg_addr_t'($urandom);
            data_in   = reg_data_t'($urandom);
            A_address = ($urandom_range(0, 3) == 0) ? D_address : reg_addr_t'($urandom);
            B_address = ($urandom_range(0, 3) == 0) ? A_address
                                                    : reg_addr_t'($urandom_range(0, 7));
            #1;
            check("rand_a", A_out, model_read(int'(A_address)));
            check("rand_b", B_out, model_read(int'(B_address)));
            model_write(write, int'(D_address), int'(data_in));
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
